alu_exec: RTL and testbench
===========================

# alu_exec

Execute-stage ALU that consumes the 4-bit `aluctl` code produced by ALU control, together with two 32-bit operands. It returns a registered result with a valid/ready handshake. Single-cycle operations complete in one cycle. `muladdmod` is a multicycle rolling-hash step, (a·BASE + b) mod PRIME, used by the signature scanner; while it runs the block stalls the pipeline through `in_ready`.

## Interface
- `BASE`, 31: hash multiplier, constant.
- `BASE_W`, 8: bit width of BASE; sets the iteration count.
- `PRIME`, 1000003: modulus, 2 ≤ PRIME < 2^31.
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `in_valid`  in  1  operation offered.
- `in_ready`  out  1  block can accept; operation accepted when `in_valid & in_ready`.
- `aluctl`  in  4  operation code.
- `a`, `b`  in  32 each  operands.
- `out_valid`  out  1  one-cycle pulse; `result`/`zero` are new.
- `result`  out  32  registered result, held until the next completion.
- `zero`  out  1  `result == 0`, registered with `result`.

## Operation
- Codes:
  - 0 AND: a&b.
  - 1 OR: a|b.
  - 2 ADD: a+b, mod 2^32.
  - 5 DXOR: a^b^(b>>8), logical shift.
  - 6 SUB: a−b, mod 2^32.
  - 7 SLT: signed a<b → 1, else 0.
  - 8 ANDOR: {a[31:16]&b[31:16], a[15:0]|b[15:0]}.
  - 10 MULADDMOD.
  - 12 NOR: ~(a|b).
  - 13 XOR: a^b.
  - Any other code returns 0 with single-cycle latency.
- FSM states and transitions:
  - IDLE: `in_ready`=1. Accepting a single-cycle op loads `result` at the clock edge; state stays IDLE. Accepting code 10 latches a and b and goes to LOAD.
  - LOAD: ra = (a ≥ PRIME ? a−PRIME : a), rb likewise; r = 0; cnt = BASE_W−1; go to ITER.
  - ITER: r = 2r mod PRIME, then if BASE[cnt], r = (r+ra) mod PRIME. Each "mod" is one conditional subtract. cnt decrements; leave after the cnt = 0 step, going to FINISH.
  - FINISH: result = (r+rb) mod PRIME; out_valid = 1 next cycle; go to IDLE.
- `in_ready` = 0 in LOAD, ITER and FINISH. `in_valid` during those states is ignored; upstream must hold its operation.
- Operands ≥ 2·PRIME receive only the single conditional subtract; this behaviour is defined as is and is not a true modulo.
- Arithmetic widths: r < PRIME < 2^31, so 2r and r+ra fit in 32 bits with no overflow.

## Timing
- Reset values: `in_ready`=1, `out_valid`=0, `result`=0, `zero`=1, state IDLE, cnt=0.
- Single-cycle op accepted in cycle T → `out_valid` in T+1.
- MULADDMOD accepted in T:
  - LOAD in T+1.
  - ITER in T+2 .. T+1+BASE_W.
  - FINISH in T+2+BASE_W.
  - `out_valid` in T+3+BASE_W (11 cycles at default BASE_W).
  - `in_ready` returns to 1 in that same cycle, so back-to-back issue is allowed.
- `reset` asserted mid-operation aborts it: no `out_valid`, and all reset values are restored on the next edge.
- Reset takes priority over a simultaneous accept.

## Configuration
- `ALU_MULADDMOD_EN` defined: code 10 behaves as described above.
- Macro undefined: the multicycle path and its states are removed. Code 10 falls into the default (result 0, latency 1) and `in_ready` is constant 1.

## Structure
- Package `alu_pkg`: 4-bit `aluctl` localparams for every code above, plus the FSM state enum.
- Sub-module `modmul_iter` holds ra/rb/r/cnt and the LOAD/ITER/FINISH sequencing. It has a start/done interface; the top handles the handshake, the single-cycle ops and the output registers.

## Test plan
- ADD a=3, b=4 → `out_valid` next cycle, result 7, zero 0. SUB a=5, b=5 → result 0, zero 1.
- SLT a=0xFFFFFFFF, b=1 → 1. DXOR a=0x000000FF, b=0x0000FF00 → 0x0000FF00. ANDOR a=0xFFFF0000, b=0x0F0F00F0 → 0x0F0F00F0.
- MULADDMOD a=5, b=7, defaults → 162 exactly 11 cycles after accept. `in_valid` with ADD held during the busy cycles is accepted only in the `out_valid` cycle.
- MULADDMOD a=b=1000002 → 999971. Back-to-back MULADDMOD → two pulses exactly 11 cycles apart.
- `reset` at cycle 5 of a MULADDMOD → no `out_valid`, result 0, `in_ready` 1 next cycle.
- With `ALU_MULADDMOD_EN` undefined: code 10 → result 0 next cycle, `in_ready` never drops. Unused code 15 → 0 in both builds.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcodes, hash constants and the multicycle state enum for alu_exec.
// The state enum is only consumed when ALU_MULADDMOD_EN is defined.
package alu_pkg;

    localparam int BASE   = 31;
    localparam int BASE_W = 8;
    localparam int CNT_W  = $clog2(BASE_W);

    localparam logic [31:0]       PRIME     = 32'd1000003;
    localparam logic [BASE_W-1:0] BASE_BITS = BASE_W'(BASE);

    localparam logic [3:0] ALU_AND       = 4'd0;
    localparam logic [3:0] ALU_OR        = 4'd1;
    localparam logic [3:0] ALU_ADD       = 4'd2;
    localparam logic [3:0] ALU_DXOR      = 4'd5;
    localparam logic [3:0] ALU_SUB       = 4'd6;
    localparam logic [3:0] ALU_SLT       = 4'd7;
    localparam logic [3:0] ALU_ANDOR     = 4'd8;
    localparam logic [3:0] ALU_MULADDMOD = 4'd10;
    localparam logic [3:0] ALU_NOR       = 4'd12;
    localparam logic [3:0] ALU_XOR       = 4'd13;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ITER,
        ST_FINISH
    } mm_state_e;

    // One conditional subtract; a true modulo only when x < 2*PRIME.
    function automatic logic [31:0] mod_sub(input logic [31:0] x);
        return (x >= PRIME) ? (x - PRIME) : x;
    endfunction

endpackage

// File: rtl/modmul_iter.sv
// Multicycle (a*BASE + b) mod PRIME by shift-and-add over the bits of BASE.
// Exists only when ALU_MULADDMOD_EN is defined.
`ifdef ALU_MULADDMOD_EN
module modmul_iter
    import alu_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_start,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic        o_ready,
    output logic        o_done,
    output logic [31:0] o_result
);

    mm_state_e        r_state;
    logic [31:0]      r_a;
    logic [31:0]      r_b;
    logic [31:0]      r_acc;
    logic [CNT_W-1:0] r_cnt;

    logic [31:0] w_dbl;
    logic [31:0] w_add;
    logic [31:0] w_next;

    assign w_dbl  = mod_sub({r_acc[30:0], 1'b0});
    assign w_add  = mod_sub(w_dbl + r_a);
    assign w_next = BASE_BITS[r_cnt] ? w_add : w_dbl;

    assign o_ready  = (r_state == ST_IDLE);
    assign o_done   = (r_state == ST_FINISH);
    assign o_result = mod_sub(r_acc + r_b);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_a     <= i_a;
                        r_b     <= i_b;
                        r_state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    // Operands are reduced in place; from here on r_a/r_b hold ra/rb.
                    r_a     <= mod_sub(r_a);
                    r_b     <= mod_sub(r_b);
                    r_acc   <= '0;
                    r_cnt   <= CNT_W'(BASE_W - 1);
                    r_state <= ST_ITER;
                end
                ST_ITER: begin
                    r_acc <= w_next;
                    if (r_cnt == '0) begin
                        r_state <= ST_FINISH;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_FINISH: begin
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`endif

// File: rtl/alu_exec.sv
// Execute-stage ALU: single-cycle ops plus an optional multicycle MULADDMOD
// enabled by ALU_MULADDMOD_EN, with a valid/ready handshake and registered result.
module alu_exec
    import alu_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_in_valid,
    output logic        o_in_ready,
    input  logic [3:0]  i_aluctl,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic        o_out_valid,
    output logic [31:0] o_result,
    output logic        o_zero
);

    logic        w_accept;
    logic        w_is_mm;
    logic        w_mm_done;
    logic [31:0] w_mm_result;
    logic [31:0] w_single;

    assign w_accept = i_in_valid & o_in_ready;

`ifdef ALU_MULADDMOD_EN
    assign w_is_mm = (i_aluctl == ALU_MULADDMOD);

    modmul_iter u_modmul_iter (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_start  (w_accept & w_is_mm),
        .i_a      (i_a),
        .i_b      (i_b),
        .o_ready  (o_in_ready),
        .o_done   (w_mm_done),
        .o_result (w_mm_result)
    );
`else
    assign w_is_mm     = 1'b0;
    assign o_in_ready  = 1'b1;
    assign w_mm_done   = 1'b0;
    assign w_mm_result = '0;
`endif

    // MULADDMOD and unused codes land in default and yield 0.
    always_comb begin
        w_single = '0;
        case (i_aluctl)
            ALU_AND:   w_single = i_a & i_b;
            ALU_OR:    w_single = i_a | i_b;
            ALU_ADD:   w_single = i_a + i_b;
            ALU_DXOR:  w_single = i_a ^ i_b ^ (i_b >> 8);
            ALU_SUB:   w_single = i_a - i_b;
            ALU_SLT:   w_single = {31'd0, $signed(i_a) < $signed(i_b)};
            ALU_ANDOR: w_single = {i_a[31:16] & i_b[31:16], i_a[15:0] | i_b[15:0]};
            ALU_NOR:   w_single = ~(i_a | i_b);
            ALU_XOR:   w_single = i_a ^ i_b;
            default:   w_single = '0;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_out_valid <= 1'b0;
            o_result    <= '0;
            o_zero      <= 1'b1;
        end else if (w_mm_done) begin
            o_out_valid <= 1'b1;
            o_result    <= w_mm_result;
            o_zero      <= (w_mm_result == '0);
        end else if (w_accept && !w_is_mm) begin
            o_out_valid <= 1'b1;
            o_result    <= w_single;
            o_zero      <= (w_single == '0);
        end else begin
            o_out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_exec.sv
// Scoreboard bench for alu_exec: driver pushes expected results and completion
// cycles, a monitor pops on every out_valid. Adapts to ALU_MULADDMOD_EN.
module tb_alu_exec;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  aluctl;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic [31:0] result;
    logic        zero;

    alu_exec dut (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_in_valid  (in_valid),
        .o_in_ready  (in_ready),
        .i_aluctl    (aluctl),
        .i_a         (a),
        .i_b         (b),
        .o_out_valid (out_valid),
        .o_result    (result),
        .o_zero      (zero)
    );

    localparam longint P_REF    = 1000003;
    localparam longint BASE_REF = 31;
`ifdef ALU_MULADDMOD_EN
    localparam bit MM_EN  = 1'b1;
    localparam int MM_LAT = 11;
`else
    localparam bit MM_EN  = 1'b0;
    localparam int MM_LAT = 1;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    logic [31:0] q_res[$];
    int          q_cyc[$];
    int          busy_from  = 0;
    int          busy_until = 0;
    bit          in_reset   = 1'b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] ref_op(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
        longint xs, ys;
        case (op)
            4'd0:  return x & y;
            4'd1:  return x | y;
            4'd2:  return x + y;
            4'd5:  return x ^ y ^ (y >> 8);
            4'd6:  return x - y;
            4'd7:  return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            4'd8:  return {x[31:16] & y[31:16], x[15:0] | y[15:0]};
            4'd10: begin
                if (!MM_EN) return 32'd0;
                xs = longint'(x) % P_REF;
                ys = longint'(y) % P_REF;
                return 32'((xs * BASE_REF + ys) % P_REF);
            end
            4'd12: return ~(x | y);
            4'd13: return x ^ y;
            default: return 32'd0;
        endcase
    endfunction

    // Called right after a negedge; the operation is accepted at the next posedge.
    task automatic issue(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
        bit done = 1'b0;
        in_valid = 1'b1;
        aluctl   = op;
        a        = x;
        b        = y;
        for (int n = 0; n < 40 && !done; n++) begin
            if (in_ready) begin
                q_res.push_back(ref_op(op, x, y));
                if (op == 4'd10) begin
                    q_cyc.push_back(cyc + MM_LAT);
                    if (MM_EN) begin
                        busy_from  = cyc + 1;
                        busy_until = cyc + MM_LAT;
                    end
                end else begin
                    q_cyc.push_back(cyc + 1);
                end
                done = 1'b1;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        if (!done) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: op %0d never accepted, expected acceptance", op);
        end
    endtask

    // Monitor: scoreboard compare on every out_valid, plus in_ready tracking.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (!in_reset) begin
                chk("in_ready", {31'd0, in_ready},
                    {31'd0, !(cyc >= busy_from && cyc < busy_until)});
                if (out_valid) begin
                    if (q_res.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL spurious_out_valid: got out_valid=1 expected 0 (cycle %0d)", cyc);
                    end else begin
                        logic [31:0] er;
                        int          ec;
                        er = q_res.pop_front();
                        ec = q_cyc.pop_front();
                        chk("result", result, er);
                        chk("zero", {31'd0, zero}, {31'd0, er == 32'd0});
                        chk("latency_cycle", cyc, ec);
                    end
                end
            end
        end
    end

    task automatic drain();
        for (int n = 0; n < 40 && q_res.size() != 0; n++) @(negedge clk);
        if (q_res.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: %0d results outstanding, expected 0", q_res.size());
            q_res.delete();
            q_cyc.delete();
        end
    endtask

    initial begin
        logic [3:0]  op;
        logic [31:0] x, y;
        reset    = 1'b1;
        in_valid = 1'b0;
        aluctl   = '0;
        a        = '0;
        b        = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_zero", {31'd0, zero}, 32'd1);
        in_reset = 1'b0;

        issue(4'd2, 32'd3, 32'd4);
        issue(4'd6, 32'd5, 32'd5);
        issue(4'd7, 32'hFFFF_FFFF, 32'd1);
        issue(4'd5, 32'h0000_00FF, 32'h0000_FF00);
        issue(4'd8, 32'hFFFF_0000, 32'h0F0F_00F0);
        issue(4'd15, 32'h1234_5678, 32'h9ABC_DEF0);
        drain();

        issue(4'd10, 32'd5, 32'd7);
        issue(4'd2, 32'd10, 32'd20);
        drain();
        issue(4'd10, 32'd1000002, 32'd1000002);
        issue(4'd10, 32'd123456, 32'd2000000);
        drain();

        // Reset during the busy window; the outstanding result must never appear.
        issue(4'd10, 32'd99, 32'd1);
        repeat (3) @(negedge clk);
        reset    = 1'b1;
        in_reset = 1'b1;
        q_res.delete();
        q_cyc.delete();
        @(negedge clk);
        reset      = 1'b0;
        busy_from  = 0;
        busy_until = 0;
        chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
        chk("abort_result", result, 32'd0);
        chk("abort_zero", {31'd0, zero}, 32'd1);
        chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
        in_reset = 1'b0;
        repeat (14) @(negedge clk);

        for (int i = 0; i < 60; i++) begin
            op = 4'($urandom_range(0, 15));
            x  = $urandom;
            y  = $urandom;
            if (op == 4'd10) begin
                x = 32'($urandom_range(0, 2000005));
                y = 32'($urandom_range(0, 2000005));
            end
            if ($urandom_range(0, 3) == 0) y = x;
            issue(op, x, y);
            if ($urandom_range(0, 4) == 0) @(negedge clk);
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
